// File: rtl/muldiv_if.sv
// Handshake/bus bundle between the execute-stage control and the muldiv unit.
// dbg_state mirrors the internal FSM state for observation.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  // start is sampled only while busy=0; done pulses one cycle as HI/LO update.
  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo, dbg_state
  );

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to compile in the divide datapath; otherwise divide starts are ignored.
module muldiv (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] d_q, d_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
`endif

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
`ifdef MULDIV_DIV_EN
  logic [64:0] shl;
  logic [33:0] trial;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;
`endif

  // Shift-add step: accumulator low half holds the unconsumed multiplier bits.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? d_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MULDIV_DIV_EN
  // Restoring step: carry-out of the 33-bit trial subtraction means "no borrow".
  assign shl      = {acc_q, 1'b0};
  assign trial    = {1'b0, shl[64:32]} + {1'b0, 1'b1, ~d_q} + 34'd1;
  assign div_next = trial[33] ? {trial[31:0], shl[31:1], 1'b1} : shl[63:0];
  assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
  assign rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  assign accept   = bus.start;
`else
  assign accept   = bus.start & ~bus.op[1];
`endif

  assign a_neg = ~bus.op[0] & bus.a[31];
  assign b_neg = ~bus.op[0] & bus.b[31];
  assign mag_a = a_neg ? (~bus.a + 32'd1) : bus.a;
  assign mag_b = b_neg ? (~bus.b + 32'd1) : bus.b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    d_d     = d_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = 6'd0;
          neg_d   = a_neg ^ b_neg;
          acc_d   = {32'd0, mag_b};
          d_d     = mag_a;
`ifdef MULDIV_DIV_EN
          div_d   = bus.op[1];
          rneg_d  = a_neg;
          dz_d    = (bus.b == 32'd0);
          if (bus.op[1]) begin
            acc_d = {32'd0, mag_a};
            d_d   = mag_b;
          end
`endif
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = mul_next;
`ifdef MULDIV_DIV_EN
        if (div_q) acc_d = div_next;
`endif
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = prod_fix[63:32];
        lo_d    = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      d_q     <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: latency, HI/LO results, moves, ignored inputs and abort on reset.
// Divide vectors run when MULDIV_DIV_EN is defined; otherwise divide starts must be ignored.
module tb_muldiv;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   bcnt;
  int   dcnt;

  muldiv_if bus();

  muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation, leaves time at E33+1 (or at the cycle budget) with cycles/busy counts.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output int nbusy);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    n     = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      n++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    reset = 1'b0;
    tick();

    // MULT -3 * 7
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, bcnt);
    chk("mult_latency", cyc, 33);
    chk("mult_busy_cycles", bcnt, 33);
    chk("mult_busy_low", {31'd0, bus.busy}, 32'd0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    // MULTU issued back-to-back in the done cycle
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt);
    chk("b2b_latency", cyc, 33);
    chk("b2b_busy_cycles", bcnt, 33);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    tick();
    chk("done_pulse_end", {31'd0, bus.done}, 32'd0);

    // Moves while idle
    bus.mthi = 1'b1;
    bus.a    = 32'h1234_5678;
    tick();
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_lo_kept", bus.lo, 32'h0000_0001);
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'hA5A5_5A5A;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("both_hi", bus.hi, 32'hA5A5_5A5A);
    chk("both_lo", bus.lo, 32'hA5A5_5A5A);

    // start beats a same-cycle move
    bus.mtlo = 1'b1;
    do_op(2'b01, 32'd6, 32'd5, cyc, bcnt);
    bus.mtlo = 1'b0;
    chk("prio_hi", bus.hi, 32'd0);
    chk("prio_lo", bus.lo, 32'd30);
    tick();

`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bcnt);
    chk("div_latency", cyc, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd100, 32'd7, cyc, bcnt);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    do_op(2'b11, 32'd5, 32'd0, cyc, bcnt);
    chk("dz_latency", cyc, 33);
    chk("dzu_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dzu_hi", bus.hi, 32'd5);
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, cyc, bcnt);
    chk("dzs_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dzs_hi", bus.hi, 32'hFFFF_FFF0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0000_0000);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc, bcnt);
    chk("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", bus.hi, 32'd1);
    tick();
`else
    // Divide start must be ignored entirely
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    bcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    chk("nodiv_busy", bcnt, 0);
    chk("nodiv_done", dcnt, 0);
    chk("nodiv_hi", bus.hi, 32'd0);
    chk("nodiv_lo", bus.lo, 32'd30);
`endif

    // MULTU 3*4 with mtlo and a second start at E10, both ignored
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.mtlo  = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    chk("busy_lo_kept", bus.lo, 32'd30);
    cyc = 10;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("ign_latency", cyc, 33);
    chk("ign_hi", bus.hi, 32'd0);
    chk("ign_lo", bus.lo, 32'd12);
    tick();
    chk("ign_no_restart", {31'd0, bus.busy}, 32'd0);

    // Reset at E20 of an operation
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'h0BAD_F00D;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
`ifdef MULDIV_DIV_EN
    bus.op = 2'b10;
`else
    bus.op = 2'b00;
`endif
    bus.start = 1'b1;
    bus.a     = 32'hFFFF_FF00;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_hi_after", bus.hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
